// File: rtl/acc_core_mc_if.sv
// Instruction- and data-memory handshake bundle for acc_core_mc.
// The core drives requests through the master modport; memories sit on the slave modport.
interface acc_core_mc_if #(
  parameter int DW = 8,
  parameter int PW = 12
);
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_data;
  logic          imem_ack;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_data, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_data, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM sequencing over req/ack memories,
// 16-entry-style register file, carry/borrow/compare flag and PC-relative branches.
module acc_core_mc #(
  parameter int DW = 8,
  parameter int PW = 12,
  parameter int RN = 16
) (
  input  logic              clk,
  input  logic              start_n,
  input  logic              go,
  acc_core_mc_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       retired
);
  localparam int RW = $clog2(RN);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pc, pc_nxt, pc_inc, pc_off;
  logic [DW-1:0] acc, acc_nxt;
  logic          flag, flag_nxt;
  logic [8:0]    ir;
  logic [DW-1:0] regs [RN];
  logic [15:0]   ret_cnt;
  logic          reg_we;

  logic [3:0]    op;
  logic [4:0]    f;
  logic [RW-1:0] ridx;
  logic [DW-1:0] rval, imm;
  logic [PW-1:0] off;
  logic [DW:0]   add_r, addi_r;
  logic          is_mem, go_ok;

  assign op     = ir[8:5];
  assign f      = ir[4:0];
  assign ridx   = f[RW-1:0];
  assign rval   = regs[ridx];
  assign imm    = {{(DW-5){1'b0}}, f};
  assign off    = {{(PW-5){f[4]}}, f};
  assign add_r  = {1'b0, acc} + {1'b0, rval};
  assign addi_r = {1'b0, acc} + {1'b0, imm};
  assign pc_inc = pc + PW'(1);
  assign pc_off = pc + off;
  assign is_mem = (op == 4'h8) || (op == 4'h9);
  assign go_ok  = go && ((state == S_IDLE) || (state == S_HALT));

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go) state_nxt = S_FETCH;
      S_FETCH: if (bus.imem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_mem)            state_nxt = S_MEM;
        else if (op == 4'hF)   state_nxt = S_HALT;
        else                   state_nxt = S_FETCH;
      end
      S_MEM:   if (bus.dmem_ack) state_nxt = S_FETCH;
      S_HALT:  if (go) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    acc_nxt  = acc;
    flag_nxt = flag;
    pc_nxt   = pc_inc;
    reg_we   = 1'b0;
    unique case (op)
      4'h0: {flag_nxt, acc_nxt} = add_r;
      4'h1: begin
        acc_nxt  = acc - rval;
        flag_nxt = acc < rval;
      end
      4'h2: acc_nxt = acc & rval;
      4'h3: acc_nxt = acc | rval;
      4'h4: acc_nxt = acc ^ rval;
      4'h5: {flag_nxt, acc_nxt} = addi_r;
      4'h6: acc_nxt = acc << f[2:0];
      4'h7: acc_nxt = acc >> f[2:0];
      4'hA: reg_we = 1'b1;
      4'hB: acc_nxt = rval;
      4'hC: if (flag) pc_nxt = pc_off;
      4'hD: pc_nxt = pc_off;
      4'hE: flag_nxt = (acc == rval);
      4'hF: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      pc      <= '0;
      acc     <= '0;
      flag    <= 1'b0;
      ir      <= '0;
      ret_cnt <= '0;
      for (int unsigned i = 0; i < RN; i++) regs[i] <= '0;
    end else if (go_ok) begin
      pc      <= '0;
      acc     <= '0;
      flag    <= 1'b0;
      ret_cnt <= '0;
    end else begin
      unique case (state)
        S_FETCH: if (bus.imem_ack) ir <= bus.imem_data;
        S_EXEC: if (!is_mem) begin
          pc   <= pc_nxt;
          acc  <= acc_nxt;
          flag <= flag_nxt;
          if (reg_we) regs[ridx] <= acc;
          if (ret_cnt != '1) ret_cnt <= ret_cnt + 16'd1;
        end
        S_MEM: if (bus.dmem_ack) begin
          if (op == 4'h8) acc <= bus.dmem_rdata;
          pc <= pc_inc;
          if (ret_cnt != '1) ret_cnt <= ret_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Requests decode straight from the state, so a reset drops them at once and
  // address/data stay frozen for the whole handshake (IR, R[] and ACC cannot change).
  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (op == 4'h9);
  assign bus.dmem_addr  = rval;
  assign bus.dmem_wdata = acc;
  assign busy           = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
  assign done           = (state == S_HALT);
  assign retired        = ret_cnt;
endmodule

// File: tb/tb_acc_core_mc.sv
// Scoreboard bench for acc_core_mc: directed programs push expected stores/halts,
// a negedge monitor pops and compares them as the core produces them.
module tb_acc_core_mc;
  localparam int DW = 8;
  localparam int PW = 12;
  localparam int RN = 16;

  logic        clk = 1'b0;
  logic        start_n = 1'b0;
  logic        go = 1'b0;
  logic        busy, done;
  logic [15:0] retired;

  acc_core_mc_if #(.DW(DW), .PW(PW)) bus ();

  acc_core_mc #(.DW(DW), .PW(PW), .RN(RN)) dut (
    .clk(clk), .start_n(start_n), .go(go), .bus(bus),
    .busy(busy), .done(done), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0]    imem [2**PW];
  logic [DW-1:0] dmem [256];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, wp = 0;
  bit ihold = 1'b0, force_ack = 1'b0, trace_en = 1'b0;

  logic          i_ack = 1'b0, d_ack = 1'b0;
  logic [8:0]    i_data = '0;
  logic [DW-1:0] d_rdata = '0;
  assign bus.imem_ack   = i_ack;
  assign bus.imem_data  = i_data;
  assign bus.dmem_ack   = d_ack;
  assign bus.dmem_rdata = d_rdata;

  typedef struct { int kind; int v0; int v1; int v2; } ev_t;  // kind 1 = store, 2 = halt
  ev_t exp_q[$];
  int  fetch_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] I(input int op, input int fld);
    logic [3:0] o;
    logic [4:0] ff;
    o  = op[3:0];
    ff = fld[4:0];
    return {o, ff};
  endfunction

  task automatic emit(input logic [8:0] w);
    imem[wp] = w;
    wp = wp + 1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2**PW; i++) imem[i] = 9'h1E0;
    wp = 0;
  endtask

  task automatic exp_store(input int a, input int d, input int cyc);
    ev_t e;
    e.kind = 1; e.v0 = a; e.v1 = d; e.v2 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic exp_halt(input int ret, input int bcyc);
    ev_t e;
    e.kind = 2; e.v0 = ret; e.v1 = bcyc; e.v2 = 0;
    exp_q.push_back(e);
  endtask

  // Memory responders: react just after the rising edge to the freshly updated requests.
  always @(posedge clk) begin
    #1;
    if (bus.imem_req && !ihold) begin
      if (icnt >= iwait) begin
        i_ack = 1'b1; i_data = imem[bus.imem_addr]; icnt = 0;
      end else begin
        i_ack = 1'b0; icnt++;
      end
    end else begin
      i_ack = 1'b0; icnt = 0;
    end
    if (force_ack) begin
      i_ack = 1'b1; i_data = 9'h1E0;
    end
    if (bus.dmem_req) begin
      if (dcnt >= dwait) begin
        d_ack = 1'b1; dcnt = 0;
        if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
        else             d_rdata = dmem[bus.dmem_addr];
      end else begin
        d_ack = 1'b0; dcnt++;
      end
    end else begin
      d_ack = 1'b0; dcnt = 0;
    end
  end

  logic [DW-1:0] cap_addr, cap_wdata;
  logic          cap_we;
  int  dcyc = 0, busy_cnt = 0;
  bit  in_d = 1'b0, dstable = 1'b1, done_prev = 1'b0, busy_prev = 1'b0;
  ev_t me;

  always @(negedge clk) begin
    if (busy && !busy_prev) busy_cnt = 1;
    else if (busy)          busy_cnt++;
    busy_prev = busy;

    if (bus.dmem_req) begin
      if (!in_d) begin
        in_d = 1'b1; dcyc = 1; dstable = 1'b1;
        cap_addr = bus.dmem_addr; cap_wdata = bus.dmem_wdata; cap_we = bus.dmem_we;
      end else begin
        dcyc++;
        if (bus.dmem_addr !== cap_addr || bus.dmem_wdata !== cap_wdata || bus.dmem_we !== cap_we)
          dstable = 1'b0;
      end
      if (bus.dmem_ack) begin
        in_d = 1'b0;
        if (bus.dmem_we) begin
          check("store_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("store_kind", 1, me.kind);
            check("store_addr", bus.dmem_addr, me.v0);
            check("store_data", bus.dmem_wdata, me.v1);
            check("store_req_cycles", dcyc, me.v2);
            check("store_stable", dstable, 1);
          end
        end
      end
    end else begin
      in_d = 1'b0;
    end

    if (trace_en && bus.imem_req && bus.imem_ack) begin
      check("fetch_expected", fetch_q.size() > 0, 1);
      if (fetch_q.size() > 0) check("fetch_addr", bus.imem_addr, fetch_q.pop_front());
    end

    if (done && !done_prev) begin
      check("halt_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        check("halt_kind", 2, me.kind);
        check("halt_retired", retired, me.v0);
        check("halt_busy_cycles", busy_cnt, me.v1);
      end
    end
    done_prev = done;
  end

  task automatic run(input int mid_go, input bit sat);
    int c;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("start_retired", retired, 0);
    check("start_addr", bus.imem_addr, 0);
    check("start_busy", busy, 1);
    if (sat) begin
      @(negedge clk) force dut.ret_cnt = 16'hFFFD;
      @(negedge clk) release dut.ret_cnt;
    end
    c = 0;
    while (c < 500 && !done) begin
      @(negedge clk);
      go = (c == mid_go);
      c++;
    end
    go = 1'b0;
    check("run_reached_halt", done, 1);
    @(posedge clk); #2;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    dmem[5] = 8'h3C;
    clear_prog();

    // Reset values and idle after release
    @(negedge clk); @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_dmem_we", bus.dmem_we, 0);
    check("rst_retired", retired, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.dmem_wdata, 0);
    start_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_until_go", busy, 0);

    // P1: ADDI 5, MOVF r1, ADD r1, HALT
    clear_prog();
    emit(I(5, 5)); emit(I(10, 1)); emit(I(0, 1)); emit(I(15, 0));
    exp_halt(4, 8);
    run(-1, 0);

    // P2: same arithmetic, observe ACC=10, FLAG=0 (BRF falls through), R1=5
    clear_prog();
    emit(I(5, 5)); emit(I(10, 1)); emit(I(0, 1)); emit(I(9, 0));
    emit(I(12, 3)); emit(I(11, 1)); emit(I(9, 0)); emit(I(15, 0));
    exp_store(0, 10, 1); exp_store(0, 5, 1); exp_halt(8, 18);
    run(-1, 0);

    // P3: nine ADDI 31 -> 0x17 with carry, BRF taken on the carry
    clear_prog();
    for (int k = 0; k < 9; k++) emit(I(5, 31));
    emit(I(12, 2)); emit(I(15, 0)); emit(I(9, 0)); emit(I(15, 0));
    exp_store(0, 8'h17, 1); exp_halt(12, 25);
    run(-1, 0);

    // P4: logic/shift/sub/load/compare mix, 1-wait data acks, stray go mid-run
    clear_prog();
    dwait = 1;
    emit(I(5, 12)); emit(I(10, 2)); emit(I(5, 10)); emit(I(2, 2));
    emit(I(3, 2));  emit(I(4, 1));  emit(I(6, 3));  emit(I(7, 2));
    emit(I(1, 2));  emit(I(9, 0));  emit(I(1, 2));  emit(I(12, 2));
    emit(I(15, 0)); emit(I(9, 0));  emit(I(10, 3)); emit(I(8, 1));
    emit(I(9, 3));  emit(I(14, 3)); emit(I(12, 2)); emit(I(11, 3));
    emit(I(14, 3)); emit(I(12, 2)); emit(I(15, 0)); emit(I(5, 1));
    emit(I(9, 0));  emit(I(15, 0));
    exp_store(0, 8'h06, 2); exp_store(0, 8'hFA, 2); exp_store(8'hFA, 8'h3C, 2);
    exp_store(0, 8'hFB, 2); exp_halt(24, 58);
    run(10, 0);

    // P5: MOVF r2 with ACC=0x40, ST r2 acked after 3 wait cycles
    clear_prog();
    dwait = 3;
    emit(I(5, 31)); emit(I(5, 31)); emit(I(5, 2)); emit(I(10, 2));
    emit(I(9, 2));  emit(I(15, 0));
    exp_store(8'h40, 8'h40, 4); exp_halt(6, 16);
    run(-1, 0);
    dwait = 0;

    // P6: branch wrap and BRF taken / not taken, traced fetch addresses
    clear_prog();
    imem[0]    = I(13, 31);
    imem[4095] = I(13, 8);
    imem[7]  = I(14, 0); imem[8] = I(3, 0); imem[9] = I(3, 0); imem[10] = I(12, 4);
    imem[14] = I(14, 1); imem[15] = I(13, 26);
    fetch_q = {0, 4095, 7, 8, 9, 10, 14, 15, 9, 10, 11};
    exp_halt(11, 22);
    trace_en = 1'b1;
    run(-1, 0);
    trace_en = 1'b0;
    check("fetch_trace_drained", fetch_q.size(), 0);

    // P7: reset while a fetch waits for its ack
    clear_prog();
    ihold = 1'b1;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("abort_fetch_pending", bus.imem_req, 1);
    @(negedge clk);
    #2 start_n = 1'b0;
    #1;
    check("abort_imem_req", bus.imem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_imem_addr", bus.imem_addr, 0);
    check("abort_dmem_req", bus.dmem_req, 0);
    @(negedge clk) start_n = 1'b1;
    ihold = 1'b0;
    force_ack = 1'b1;
    @(negedge clk); @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_ignored_busy", busy, 0);
    check("late_ack_ignored_req", bus.imem_req, 0);
    emit(I(11, 1)); emit(I(9, 0)); emit(I(5, 7)); emit(I(10, 1)); emit(I(15, 0));
    exp_store(0, 0, 1); exp_halt(5, 11);
    run(-1, 0);

    // P8: retired counter pushed near the top saturates at FFFF
    clear_prog();
    for (int k = 0; k < 7; k++) emit(I(3, 0));
    emit(I(15, 0));
    exp_halt(16'hFFFF, 16);
    run(-1, 1);

    // P9: go from HALT restarts at PC 0 with retired cleared, R1 kept
    clear_prog();
    emit(I(11, 1)); emit(I(9, 0)); emit(I(15, 0));
    exp_store(0, 7, 1); exp_halt(3, 7);
    run(-1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
